bfly_out_serializer: RTL and testbench
======================================

Name: bfly_out_serializer

Overview:
Output-side companion of the radix-2 butterfly stage in the 512-point, 16-lane FFT datapath. It takes the butterfly's parallel sum (do1) and difference (do2) lane vectors, passes the sum half straight through, and buffers the difference half. It then replays the buffered half, so the next stage sees one contiguous 16-lane stream of COUNT beats per frame. This is the inverse of the butterfly's input delay line, which gathers the first half-frame before combining.

Parameters:
WIDTH, 10, signed sample width of every re/im lane (butterfly output width)
NUM, 16, number of parallel lanes
DATA, 512, points per frame
COUNT, DATA/NUM, output beats per frame (32); HALF = COUNT/2 = 16 input beats per frame

Ports:
clk  in  1  clock
rstn  in  1  reset
do1_re  in  WIDTH x [0:NUM-1]  butterfly sum, real
do1_im  in  WIDTH x [0:NUM-1]  butterfly sum, imag
do2_re  in  WIDTH x [0:NUM-1]  butterfly difference, real
do2_im  in  WIDTH x [0:NUM-1]  butterfly difference, imag
valid_in  in  1  do1/do2 beat valid
dout_i  out  WIDTH x [0:NUM-1]  serialized real lanes, registered
dout_q  out  WIDTH x [0:NUM-1]  serialized imag lanes, registered
valid_out  out  1  dout valid
sof  out  1  pulse with first output beat of a frame
eof  out  1  pulse with last output beat of a frame
overrun  out  1  sticky: valid_in seen while draining

Interface: reset rstn, asynchronous, active-low; clock clk.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): all outputs go to 0. State goes to IDLE. Both counters go to 0. overrun goes to 0. Buffer contents need not be cleared.
- Storage: HALF-entry buffer, each entry 2*NUM*WIDTH bits (do2 re/im for one beat). It is written at wr_cnt and read at rd_cnt.
- FSM states: IDLE, PASS, DRAIN.
- IDLE:
  - valid_in=1: accept beat 0. Register do1 onto dout next cycle, with valid_out=1 and sof=1. Write do2 to buf[0]. Set wr_cnt=1 and go to PASS. If HALF==1, go directly to DRAIN.
  - valid_in=0: stay in IDLE with valid_out=0.
- PASS:
  - Each valid_in beat: dout<=do1, valid_out=1, buf[wr_cnt]<=do2, wr_cnt++.
  - Gaps (valid_in=0) are legal. The counter holds and valid_out=0 on the following cycle.
  - On the beat where wr_cnt==HALF-1: go to DRAIN, set wr_cnt=0 and rd_cnt=0.
- DRAIN:
  - Every cycle, unconditionally: dout<=buf[rd_cnt], valid_out=1, rd_cnt++.
  - When rd_cnt==HALF-1: eof=1 on that output beat, then go to IDLE.
  - With no PASS gaps, valid_out is high for exactly COUNT consecutive cycles.
- Latency: 1 cycle from an accepted do1 beat to dout. The first drain beat directly follows the last pass beat.
- Overrun: valid_in=1 in any DRAIN cycle, including the last one, drops that beat (no write, no pass) and sets overrun=1. overrun stays set until reset. The FSM sequence is unaffected.
- Outputs when valid_out=0: dout holds its last value; sof=0; eof=0.
- Widths: no growth. Lanes are copied bit-exact unless the optional feature is enabled. Lane k in maps to lane k out.

Optional Feature:
Macro BFLY_SER_HALF_SCALE_EN.
- Defined: every output lane value is (x + 1) >>> 1, computed in WIDTH+1 bits and truncated back to WIDTH. This is round-half-up divide-by-2 for per-stage scaling. Range check: max 511 gives 256 and min -512 gives -256, so no saturation is needed. Applied on both the pass path and the drain path, with latency unchanged.
- Undefined: pass-through, bit-exact.

Test Plan:
- Reset then 16 contiguous beats: do1 lane k = beat*16+k, do2 = -(beat*16+k).
  - Required: valid_out high for 32 consecutive cycles, starting 1 cycle after the first beat.
  - Beats 0-15 carry do1 values; beats 16-31 carry do2 values in order.
  - sof on beat 0, eof on beat 31.
- Same frame with valid_in low for 3 cycles after beat 5.
  - Required: 3-cycle valid_out gap after output beat 5; drain still 16 contiguous beats; data order intact.
- Two frames, second starting the cycle after eof: both frames emitted correctly and overrun=0. Then start a frame 4 cycles into a drain.
  - Required: overrun=1, the drain continues unchanged, and the overlapping beats are dropped.
- rstn asserted at drain beat 7: outputs 0 immediately, FSM in IDLE. A new frame after release is output correctly.
- Boundary values: do1 lanes = 511, do2 lanes = -512.
  - Macro undefined: outputs are exactly 511 and -512.
  - Macro defined: outputs are 256 and -256; input 3 gives 2; input -3 gives -1.

Source files
------------

// File: rtl/bfly_out_serializer.sv
// bfly_out_serializer
//   Output side of the radix-2 butterfly stage. The sum half (do1) goes
//   straight to the registered output while the difference half (do2) is
//   written into a HALF-entry buffer; the buffer is then replayed so the
//   next stage sees one contiguous COUNT-beat stream per frame.
//
//   Optional build macro: BFLY_SER_HALF_SCALE_EN
//     defined   -> every output lane is (x + 1) >>> 1 (round-half-up /2)
//     undefined -> lanes copied bit-exact
module bfly_out_serializer #(
    parameter int WIDTH = 10,
    parameter int NUM   = 16,
    parameter int DATA  = 512,
    parameter int COUNT = DATA / NUM
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] do1_re [0:NUM-1],
    input  logic signed [WIDTH-1:0] do1_im [0:NUM-1],
    input  logic signed [WIDTH-1:0] do2_re [0:NUM-1],
    input  logic signed [WIDTH-1:0] do2_im [0:NUM-1],
    input  logic                    valid_in,
    output logic signed [WIDTH-1:0] dout_i [0:NUM-1],
    output logic signed [WIDTH-1:0] dout_q [0:NUM-1],
    output logic                    valid_out,
    output logic                    sof,
    output logic                    eof,
    output logic                    overrun
);

    localparam int HALF = COUNT / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;

    // control decoded from the current state
    logic             pass_en;
    logic             drain_en;
    logic [CW-1:0]    wr_addr;
    logic             sof_d;
    logic             eof_d;
    logic             ovr_set;

    // registered outputs
    logic signed [WIDTH-1:0] dout_re_q [0:NUM-1];
    logic signed [WIDTH-1:0] dout_im_q [0:NUM-1];
    logic                    valid_q;
    logic                    sof_q;
    logic                    eof_q;
    logic                    overrun_q;

    // difference-half buffer, one entry per input beat
    logic signed [WIDTH-1:0] mem_re_q [0:HALF-1][0:NUM-1];
    logic signed [WIDTH-1:0] mem_im_q [0:HALF-1][0:NUM-1];

    function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] x);
`ifdef BFLY_SER_HALF_SCALE_EN
        logic signed [WIDTH:0] t;
        t = {x[WIDTH-1], x};
        t = t + (WIDTH+1)'(1);
        return WIDTH'(t >>> 1);
`else
        return x;
`endif
    endfunction

    // state and counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // next-state and counter update
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (HALF == 1) begin
                        state_d  = DRAIN;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                    end else begin
                        state_d  = PASS;
                        wr_cnt_d = CW'(1);
                    end
                end
            end
            PASS: begin
                if (valid_in) begin
                    if (wr_cnt_q == CW'(HALF - 1)) begin
                        state_d  = DRAIN;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (rd_cnt_q == CW'(HALF - 1)) begin
                    state_d  = IDLE;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end
        endcase
    end

    // per-state datapath controls; beats arriving while draining are dropped
    always_comb begin
        pass_en  = 1'b0;
        drain_en = 1'b0;
        wr_addr  = wr_cnt_q;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        ovr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                pass_en = valid_in;
                wr_addr = '0;
                sof_d   = valid_in;
            end
            PASS: begin
                pass_en = valid_in;
            end
            DRAIN: begin
                drain_en = 1'b1;
                eof_d    = (rd_cnt_q == CW'(HALF - 1));
                ovr_set  = valid_in;
            end
            default: begin
                pass_en = 1'b0;
            end
        endcase
    end

    // buffer write of the difference half (contents need no reset)
    always_ff @(posedge clk) begin
        if (pass_en) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                mem_re_q[wr_addr][k] <= do2_re[k];
                mem_im_q[wr_addr][k] <= do2_im[k];
            end
        end
    end

    // output register: pass path while accepting, buffer replay while draining
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                dout_re_q[k] <= '0;
                dout_im_q[k] <= '0;
            end
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= pass_en || drain_en;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end
            if (pass_en) begin
                for (int unsigned k = 0; k < NUM; k++) begin
                    dout_re_q[k] <= scale(do1_re[k]);
                    dout_im_q[k] <= scale(do1_im[k]);
                end
            end else if (drain_en) begin
                for (int unsigned k = 0; k < NUM; k++) begin
                    dout_re_q[k] <= scale(mem_re_q[rd_cnt_q][k]);
                    dout_im_q[k] <= scale(mem_im_q[rd_cnt_q][k]);
                end
            end
        end
    end

    assign dout_i    = dout_re_q;
    assign dout_q    = dout_im_q;
    assign valid_out = valid_q;
    assign sof       = sof_q;
    assign eof       = eof_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_bfly_out_serializer.sv
// Directed bench for bfly_out_serializer with a cycle-stamped scoreboard.
// Honours BFLY_SER_HALF_SCALE_EN in its expected-value model.
module tb_bfly_out_serializer;

    localparam int W = 10;
    localparam int N = 16;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid_in = 1'b0;
    logic signed [W-1:0] d1r [0:N-1];
    logic signed [W-1:0] d1i [0:N-1];
    logic signed [W-1:0] d2r [0:N-1];
    logic signed [W-1:0] d2i [0:N-1];
    logic signed [W-1:0] oi  [0:N-1];
    logic signed [W-1:0] oq  [0:N-1];
    logic valid_out, sof, eof, overrun;

    bfly_out_serializer #(.WIDTH(W), .NUM(N), .DATA(512)) dut (
        .clk(clk), .rstn(rstn),
        .do1_re(d1r), .do1_im(d1i), .do2_re(d2r), .do2_im(d2i),
        .valid_in(valid_in),
        .dout_i(oi), .dout_q(oq),
        .valid_out(valid_out), .sof(sof), .eof(eof), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [N-1:0][W-1:0] re;
        logic [N-1:0][W-1:0] im;
        logic                sof;
        logic                eof;
        logic [31:0]         cyc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    function automatic int sc(input int x);
`ifdef BFLY_SER_HALF_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    // m=0: counting pattern with im offset s; m=1: boundary values
    function automatic int v1r(input int m, input int s, input int b, input int k);
        if (m != 0) return (k % 2 == 0) ? 511 : 3;
        return b * 16 + k + 0 * s;
    endfunction
    function automatic int v1i(input int m, input int s, input int b, input int k);
        if (m != 0) return (k % 2 == 0) ? 511 : -3;
        return s - (b * 16 + k);
    endfunction
    function automatic int v2r(input int m, input int s, input int b, input int k);
        if (m != 0) return (k % 2 == 0) ? -512 : -3;
        return -(b * 16 + k) + 0 * s;
    endfunction
    function automatic int v2i(input int m, input int s, input int b, input int k);
        if (m != 0) return (k % 2 == 0) ? -512 : 3;
        return (b * 16 + k) - s;
    endfunction

    // monitor: pop and compare on every valid output beat
    logic [N-1:0][W-1:0] obs_re, obs_im;
    exp_t e_m;
    always @(negedge clk) begin
        if (rstn && valid_out) begin
            for (int k = 0; k < N; k++) begin
                obs_re[k] = oi[k];
                obs_im[k] = oq[k];
            end
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_beat cyc=%0d observed valid_out=1 expected valid_out=0", cyc);
            end
            if (q.size() > 0) begin
                e_m = q.pop_front();
                tests++;
                assert (cyc === int'(e_m.cyc)) else begin
                    fails++;
                    $error("FAIL beat_cycle observed=%0d expected=%0d", cyc, e_m.cyc);
                end
                tests++;
                assert (obs_re === e_m.re) else begin
                    fails++;
                    $error("FAIL dout_i cyc=%0d observed=%h expected=%h", cyc, obs_re, e_m.re);
                end
                tests++;
                assert (obs_im === e_m.im) else begin
                    fails++;
                    $error("FAIL dout_q cyc=%0d observed=%h expected=%h", cyc, obs_im, e_m.im);
                end
                tests++;
                assert ({sof, eof} === {e_m.sof, e_m.eof}) else begin
                    fails++;
                    $error("FAIL sof_eof cyc=%0d observed=%b%b expected=%b%b", cyc, sof, eof, e_m.sof, e_m.eof);
                end
            end
        end else if (rstn) begin
            tests++;
            assert ({sof, eof} === 2'b00) else begin
                fails++;
                $error("FAIL idle_flags cyc=%0d observed sof/eof=%b%b expected=00", cyc, sof, eof);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        logic any_lane;
        any_lane = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (oi[k] !== '0 || oq[k] !== '0) any_lane = 1'b1;
        end
        chk({tag, "_flags"}, 64'({valid_out, sof, eof, overrun}), 64'(0));
        chk({tag, "_dout"}, 64'(any_lane), 64'(0));
    endtask

    task automatic drive_frame(input int m, input int s, input int gap_after, input int gap_len,
                               input int start_cap, output int last_cap);
        exp_t e;
        last_cap = 0;
        for (int b = 0; b < H; b++) begin
            @(negedge clk);
            while (cyc + 1 < start_cap) @(negedge clk);
            for (int k = 0; k < N; k++) begin
                d1r[k] = W'(v1r(m, s, b, k));
                d1i[k] = W'(v1i(m, s, b, k));
                d2r[k] = W'(v2r(m, s, b, k));
                d2i[k] = W'(v2i(m, s, b, k));
                e.re[k] = W'(sc(v1r(m, s, b, k)));
                e.im[k] = W'(sc(v1i(m, s, b, k)));
            end
            valid_in = 1'b1;
            e.cyc = 32'(cyc + 1);
            e.sof = (b == 0);
            e.eof = 1'b0;
            q.push_back(e);
            last_cap = cyc + 1;
            if (b == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                end
            end
        end
        for (int j = 0; j < H; j++) begin
            for (int k = 0; k < N; k++) begin
                e.re[k] = W'(sc(v2r(m, s, j, k)));
                e.im[k] = W'(sc(v2i(m, s, j, k)));
            end
            e.cyc = 32'(last_cap + 1 + j);
            e.sof = 1'b0;
            e.eof = (j == H - 1);
            q.push_back(e);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        chk({tag, "_drained"}, 64'(q.size()), 64'(0));
        repeat (6) @(negedge clk);
    endtask

    int la, lb, lc, ld;

    initial begin
        for (int k = 0; k < N; k++) begin
            d1r[k] = '0; d1i[k] = '0; d2r[k] = '0; d2i[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        rstn = 1'b1;

        // contiguous frame
        drive_frame(0, 300, -1, 0, 0, la);
        wait_empty("frame_contig");

        // 3-cycle gap after beat 5
        drive_frame(0, 250, 5, 3, 0, la);
        wait_empty("frame_gap");

        // back-to-back frames, second starts the cycle after eof
        drive_frame(0, 200, -1, 0, 0, la);
        drive_frame(0, 150, -1, 0, la + 17, lb);
        while (cyc + 1 < lb + 5) @(negedge clk);
        chk("overrun_clear", 64'(overrun), 64'(0));
        // beats landing inside the drain, incl. its last cycle, must be dropped
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) d1r[k] = W'(100 + i);
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        while (cyc + 1 < lb + 16) @(negedge clk);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        wait_empty("frame_overrun");
        chk("overrun_sticky", 64'(overrun), 64'(1));

        // async reset in the middle of the drain (drain beat 7)
        drive_frame(0, 100, -1, 0, 0, lc);
        while (cyc < lc + 8) @(negedge clk);
        #1 rstn = 1'b0;
        #1 chk_reset("reset_mid_drain");
        q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        drive_frame(0, 50, -1, 0, 0, ld);
        wait_empty("frame_after_reset");

        // boundary values
        drive_frame(1, 0, -1, 0, 0, ld);
        wait_empty("frame_boundary");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
